// File: rtl/rpn_program_runner.sv
// Sequencer that walks an instruction ROM and feeds one RPN calculator, one
// step pulse per instruction, guarding each step against the live stack depth.
module rpn_program_runner #(
    parameter int N = 16,
    parameter int M = 10,
    parameter int P = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         start,
    output logic [P-1:0] prog_addr,
    input  logic [N+2:0] prog_data,
    output logic         calc_nrst,
    output logic         calc_step,
    output logic         calc_push,
    output logic [1:0]   calc_op,
    output logic [N-1:0] calc_d,
    input  logic [N-1:0] calc_out,
    input  logic [M-1:0] calc_cnt,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [N-1:0] result,
    output logic [P:0]   icount
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FETCH, S_STROBE} state_t;

    localparam logic [1:0]   OP_NONE  = 2'b00;
    localparam logic [1:0]   OP_NEG   = 2'b01;
    localparam logic [M-1:0] CNT_FULL = '1;
    localparam logic [M-1:0] CNT_ZERO = '0;
    localparam logic [M-1:0] CNT_ONE  = M'(1);
    localparam logic [M-1:0] CNT_TWO  = M'(2);
    localparam logic [P-1:0] PC_LAST  = '1;
    localparam logic [P-1:0] PC_ONE   = P'(1);
    localparam logic [P:0]   IC_ONE   = (P+1)'(1);

    state_t         r_state;
    state_t         w_next;
    logic [P-1:0]   r_pc;
    logic [P:0]     r_icount;
    logic [N-1:0]   r_result;
    logic           r_busy;
    logic           r_done;
    logic           r_err;
    logic           r_wrap;
    logic           r_step;
    logic           r_push;
    logic [1:0]     r_op;
    logic [N-1:0]   r_d;

    logic           w_clr;
    logic           w_push;
    logic [1:0]     w_op;
    logic [N-1:0]   w_imm;
    logic           w_halt;
    logic           w_fault;
    logic           w_end;
    logic           w_err_end;

    assign w_push = prog_data[N+2];
    assign w_op   = prog_data[N+1:N];
    assign w_imm  = prog_data[N-1:0];
    assign w_halt = !w_push && (w_op == OP_NONE);

    // Any of these would make the calculator act on a stack that cannot support it.
    assign w_fault = (w_push && (calc_cnt == CNT_FULL))
                  || ((w_op == OP_NEG) && (calc_cnt == CNT_ZERO))
                  || (w_op[1] && (calc_cnt < CNT_TWO));

    // After a ROM wrap the fetched word is ignored: the run ends on this FETCH.
    assign w_end     = (r_state == S_FETCH) && (r_wrap || w_halt || w_fault);
    assign w_err_end = r_wrap || w_fault || (w_halt && (calc_cnt != CNT_ONE));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = start ? S_CLEAR : S_IDLE;
            S_CLEAR:  w_next = S_FETCH;
            S_FETCH:  w_next = w_end ? S_IDLE : S_STROBE;
            S_STROBE: w_next = S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_clr = 1'b0;
        if (r_state == S_CLEAR) begin
            w_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pc     <= '0;
            r_icount <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_wrap   <= 1'b0;
            r_step   <= 1'b0;
            r_push   <= 1'b0;
            r_op     <= OP_NONE;
            r_d      <= '0;
        end else begin
            r_done <= 1'b0;
            r_step <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy   <= 1'b1;
                        r_err    <= 1'b0;
                        r_wrap   <= 1'b0;
                        r_icount <= '0;
                        r_pc     <= '0;
                    end
                end
                S_FETCH: begin
                    if (w_end) begin
                        r_result <= calc_out;
                        r_err    <= w_err_end;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_push <= w_push;
                        r_op   <= w_op;
                        r_d    <= w_imm;
                        r_step <= 1'b1;
                    end
                end
                S_STROBE: begin
                    r_icount <= r_icount + IC_ONE;
                    r_pc     <= r_pc + PC_ONE;
                    if (r_pc == PC_LAST) begin
                        r_wrap <= 1'b1;
                        r_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign calc_nrst = nrst & ~w_clr;
    assign prog_addr = r_pc;
    assign calc_step = r_step;
    assign calc_push = r_push;
    assign calc_op   = r_op;
    assign calc_d    = r_d;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign result    = r_result;
    assign icount    = r_icount;

endmodule

// File: tb/tb_rpn_program_runner.sv
// Bench for rpn_program_runner: three runners (default, M=2, P=3) each driving a
// behavioural calculator, checked against a program-level reference model.
module tb_rpn_program_runner;

    logic clk = 1'b0;
    logic nrst = 1'b1;
    logic start = 1'b0;
    int   sel = 0;
    int   total = 0;
    int   bad = 0;
    int   step_cnt = 0;
    logic [18:0] prog_q[$];

    logic [18:0] rom0[256];
    logic [18:0] rom1[256];
    logic [18:0] rom2[8];

    always #5 clk = ~clk;

    function automatic logic [18:0] i_push(input logic [15:0] v);
        return {1'b1, 2'b00, v};
    endfunction

    function automatic logic [18:0] i_op(input logic [1:0] op);
        return {1'b0, op, 16'h0000};
    endfunction

    function automatic logic [15:0] alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'd1:    return 16'h0000 - a;
            2'd2:    return a + b;
            2'd3:    return a * b;
            default: return a;
        endcase
    endfunction

    // ---------------- instance 0: N=16 M=10 P=8 ----------------
    logic [7:0]  addr0;
    logic        cn0, step0, push0, busy0, done0, err0;
    logic [1:0]  op0;
    logic [15:0] d0, res0;
    logic [15:0] out0 = 16'h0;
    logic [9:0]  cnt0 = 10'h0;
    logic [8:0]  ic0;
    logic [15:0] stk0[$];

    rpn_program_runner #(.N(16), .M(10), .P(8)) u0 (
        .clk(clk), .nrst(nrst), .start(start && sel == 0), .prog_addr(addr0),
        .prog_data(rom0[addr0]), .calc_nrst(cn0), .calc_step(step0), .calc_push(push0),
        .calc_op(op0), .calc_d(d0), .calc_out(out0), .calc_cnt(cnt0), .busy(busy0),
        .done(done0), .err(err0), .result(res0), .icount(ic0)
    );

    always @(posedge step0 or negedge cn0) begin
        logic [15:0] a, b;
        if (!cn0) stk0.delete();
        else if (push0) stk0.push_back(d0);
        else if (op0 != 2'd0 && stk0.size() >= (op0[1] ? 2 : 1)) begin
            a = stk0.pop_back();
            b = op0[1] ? stk0.pop_back() : 16'h0;
            stk0.push_back(alu(op0, a, b));
        end
        cnt0 = 10'(stk0.size());
        out0 = (stk0.size() > 0) ? stk0[$] : 16'h0;
    end

    // ---------------- instance 1: M=2 ----------------
    logic [7:0]  addr1;
    logic        cn1, step1, push1, busy1, done1, err1;
    logic [1:0]  op1;
    logic [15:0] d1, res1;
    logic [15:0] out1 = 16'h0;
    logic [1:0]  cnt1 = 2'h0;
    logic [8:0]  ic1;
    logic [15:0] stk1[$];

    rpn_program_runner #(.N(16), .M(2), .P(8)) u1 (
        .clk(clk), .nrst(nrst), .start(start && sel == 1), .prog_addr(addr1),
        .prog_data(rom1[addr1]), .calc_nrst(cn1), .calc_step(step1), .calc_push(push1),
        .calc_op(op1), .calc_d(d1), .calc_out(out1), .calc_cnt(cnt1), .busy(busy1),
        .done(done1), .err(err1), .result(res1), .icount(ic1)
    );

    always @(posedge step1 or negedge cn1) begin
        logic [15:0] a, b;
        if (!cn1) stk1.delete();
        else if (push1) stk1.push_back(d1);
        else if (op1 != 2'd0 && stk1.size() >= (op1[1] ? 2 : 1)) begin
            a = stk1.pop_back();
            b = op1[1] ? stk1.pop_back() : 16'h0;
            stk1.push_back(alu(op1, a, b));
        end
        cnt1 = 2'(stk1.size());
        out1 = (stk1.size() > 0) ? stk1[$] : 16'h0;
    end

    // ---------------- instance 2: P=3 ----------------
    logic [2:0]  addr2;
    logic        cn2, step2, push2, busy2, done2, err2;
    logic [1:0]  op2;
    logic [15:0] d2, res2;
    logic [15:0] out2 = 16'h0;
    logic [9:0]  cnt2 = 10'h0;
    logic [3:0]  ic2;
    logic [15:0] stk2[$];

    rpn_program_runner #(.N(16), .M(10), .P(3)) u2 (
        .clk(clk), .nrst(nrst), .start(start && sel == 2), .prog_addr(addr2),
        .prog_data(rom2[addr2]), .calc_nrst(cn2), .calc_step(step2), .calc_push(push2),
        .calc_op(op2), .calc_d(d2), .calc_out(out2), .calc_cnt(cnt2), .busy(busy2),
        .done(done2), .err(err2), .result(res2), .icount(ic2)
    );

    always @(posedge step2 or negedge cn2) begin
        logic [15:0] a, b;
        if (!cn2) stk2.delete();
        else if (push2) stk2.push_back(d2);
        else if (op2 != 2'd0 && stk2.size() >= (op2[1] ? 2 : 1)) begin
            a = stk2.pop_back();
            b = op2[1] ? stk2.pop_back() : 16'h0;
            stk2.push_back(alu(op2, a, b));
        end
        cnt2 = 10'(stk2.size());
        out2 = (stk2.size() > 0) ? stk2[$] : 16'h0;
    end

    // ---------------- selected-instance view ----------------
    wire        m_done = (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
    wire        m_busy = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
    wire        m_err  = (sel == 0) ? err0  : (sel == 1) ? err1  : err2;
    wire        m_step = (sel == 0) ? step0 : (sel == 1) ? step1 : step2;
    wire [15:0] m_res  = (sel == 0) ? res0  : (sel == 1) ? res1  : res2;
    wire [8:0]  m_ic   = (sel == 0) ? ic0   : (sel == 1) ? ic1   : {5'b0, ic2};

    always @(posedge m_step) step_cnt = step_cnt + 1;

    task automatic load_rom(input int which);
        logic [18:0] w;
        for (int i = 0; i < 256; i++) begin
            w = (i < prog_q.size()) ? prog_q[i] : 19'h0;
            if (which == 0) rom0[i] = w;
            else if (which == 1) rom1[i] = w;
            else if (i < 8) rom2[i] = w;
        end
    endtask

    // Program-level reference: walk the instruction list with a plain stack.
    task automatic ref_run(input int full, input int romsz, output logic [15:0] r,
                           output logic e, output int ic);
        logic [15:0] s[$];
        logic [18:0] ins;
        logic [15:0] a, b;
        int pc;
        bit stop;
        ic = 0; pc = 0; e = 1'b0; stop = 0;
        while (!stop) begin
            ins = (pc < prog_q.size()) ? prog_q[pc] : 19'h0;
            if (pc == romsz) begin e = 1'b1; stop = 1; end
            else if (!ins[18] && ins[17:16] == 2'd0) begin e = (s.size() != 1); stop = 1; end
            else if ((ins[18] && s.size() == full) || (ins[17:16] == 2'd1 && s.size() == 0)
                     || (ins[17] && s.size() < 2)) begin e = 1'b1; stop = 1; end
            else begin
                if (ins[18]) s.push_back(ins[15:0]);
                else begin
                    a = s.pop_back();
                    b = ins[17] ? s.pop_back() : 16'h0;
                    s.push_back(alu(ins[17:16], a, b));
                end
                ic++; pc++;
            end
        end
        r = (s.size() > 0) ? s[$] : 16'h0;
    endtask

    task automatic run_prog(input int mid, output int edges, output logic [15:0] r,
                            output logic e, output int ic, output int st);
        edges = -1;
        @(negedge clk);
        step_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            start = (k == mid);
            if (m_done) begin edges = k; break; end
        end
        start = 1'b0;
        r = m_res; e = m_err; ic = int'(m_ic); st = step_cnt;
        total++;
        if (edges < 0) begin bad++; $display("FAIL run_timeout got no done want done within 100 edges"); end
    endtask

    task automatic test_reset;
        sel = 0;
        #1 nrst = 1'b0;
        #12;
        total++;
        if ({busy0, done0, err0, step0, push0, op0, d0, res0, ic0, addr0} !== '0) begin
            bad++; $display("FAIL reset_outputs got %h want 0", {busy0, done0, err0, step0, push0, op0, d0, res0, ic0, addr0});
        end
        total++;
        if (cn0 !== 1'b0) begin bad++; $display("FAIL reset_calc_nrst got %b want 0", cn0); end
        @(negedge clk) nrst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (cn0 !== 1'b1) begin bad++; $display("FAIL idle_calc_nrst got %b want 1", cn0); end
        total++;
        if ({busy0, done0} !== 2'b00) begin bad++; $display("FAIL idle_busy_done got %b want 00", {busy0, done0}); end
    endtask

    task automatic test_prog1;
        int ed, ic, st; logic [15:0] r; logic e;
        sel = 0;
        prog_q = '{i_push(16'd3), i_push(16'd4), i_op(2'd2), i_push(16'd5), i_op(2'd3), 19'h0};
        load_rom(0);
        run_prog(0, ed, r, e, ic, st);
        total++; if (ed !== 12) begin bad++; $display("FAIL p1_edge got %0d want 12", ed); end
        total++; if (r !== 16'd35) begin bad++; $display("FAIL p1_result got %0d want 35", r); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL p1_err got %b want 0", e); end
        total++; if (ic !== 5) begin bad++; $display("FAIL p1_icount got %0d want 5", ic); end
        total++; if (st !== 5) begin bad++; $display("FAIL p1_steps got %0d want 5", st); end
        @(posedge clk); #1;
        total++; if ({done0, busy0} !== 2'b00) begin bad++; $display("FAIL p1_done_pulse got %b want 00", {done0, busy0}); end
    endtask

    task automatic test_underflow;
        int ed, ic, st; logic [15:0] r; logic e;
        sel = 0;
        prog_q = '{i_op(2'd2), i_push(16'd1), 19'h0};
        load_rom(0);
        run_prog(0, ed, r, e, ic, st);
        total++; if (ed !== 2) begin bad++; $display("FAIL uf_edge got %0d want 2", ed); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL uf_err got %b want 1", e); end
        total++; if (r !== 16'd0) begin bad++; $display("FAIL uf_result got %0d want 0", r); end
        total++; if (ic !== 0) begin bad++; $display("FAIL uf_icount got %0d want 0", ic); end
        total++; if (st !== 0) begin bad++; $display("FAIL uf_steps got %0d want 0", st); end
    endtask

    task automatic test_full;
        int ed, ic, st; logic [15:0] r; logic e;
        sel = 1;
        prog_q = '{i_push(16'd1), i_push(16'd2), i_push(16'd3), i_push(16'd4), 19'h0};
        load_rom(1);
        run_prog(0, ed, r, e, ic, st);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL full_err got %b want 1", e); end
        total++; if (ic !== 3) begin bad++; $display("FAIL full_icount got %0d want 3", ic); end
        total++; if (r !== 16'd3) begin bad++; $display("FAIL full_result got %0d want 3", r); end
        total++; if (ed !== 8) begin bad++; $display("FAIL full_edge got %0d want 8", ed); end
    endtask

    task automatic test_wrap;
        int ed, ic, st; logic [15:0] r; logic e;
        sel = 2;
        prog_q = '{i_push(16'd7), i_op(2'd1), i_op(2'd1), i_op(2'd1), i_op(2'd1),
                   i_op(2'd1), i_op(2'd1), i_op(2'd1)};
        load_rom(2);
        run_prog(0, ed, r, e, ic, st);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL wrap_err got %b want 1", e); end
        total++; if (ic !== 8) begin bad++; $display("FAIL wrap_icount got %0d want 8", ic); end
        total++; if (r !== 16'hFFF9) begin bad++; $display("FAIL wrap_result got %h want fff9", r); end
        total++; if (ed !== 18) begin bad++; $display("FAIL wrap_edge got %0d want 18", ed); end
        total++; if (st !== 8) begin bad++; $display("FAIL wrap_steps got %0d want 8", st); end
    endtask

    task automatic test_start_ignored;
        int ed, ic, st; logic [15:0] r; logic e;
        sel = 0;
        prog_q = '{i_push(16'd2), i_push(16'd9), 19'h0};
        load_rom(0);
        run_prog(3, ed, r, e, ic, st);
        total++; if (ed !== 6) begin bad++; $display("FAIL si_edge got %0d want 6", ed); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL si_err got %b want 1", e); end
        total++; if (r !== 16'd9) begin bad++; $display("FAIL si_result got %0d want 9", r); end
        total++; if (ic !== 2) begin bad++; $display("FAIL si_icount got %0d want 2", ic); end
        repeat (3) @(posedge clk);
        #1;
        total++; if ({busy0, ic0} !== {1'b0, 9'd2}) begin bad++; $display("FAIL si_idle got busy=%b ic=%0d want busy=0 ic=2", busy0, ic0); end
    endtask

    task automatic test_reset_midrun;
        int ed, ic, st; logic [15:0] r; logic e; bit seen;
        sel = 0;
        prog_q = '{i_push(16'd3), i_push(16'd4), i_op(2'd2), i_push(16'd5), i_op(2'd3), 19'h0};
        load_rom(0);
        @(negedge clk);
        step_cnt = 0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (step_cnt >= 3) begin seen = 1; break; end
        end
        total++; if (!seen) begin bad++; $display("FAIL mr_step3 got %0d steps want 3", step_cnt); end
        nrst = 1'b0;
        #1;
        total++;
        if ({busy0, done0, err0, step0, push0, op0, d0, res0, ic0, addr0} !== '0) begin
            bad++; $display("FAIL mr_outputs got %h want 0", {busy0, done0, err0, step0, push0, op0, d0, res0, ic0, addr0});
        end
        total++; if (cn0 !== 1'b0) begin bad++; $display("FAIL mr_calc_nrst got %b want 0", cn0); end
        @(negedge clk) nrst = 1'b1;
        run_prog(0, ed, r, e, ic, st);
        total++; if (r !== 16'd35) begin bad++; $display("FAIL mr_rerun_result got %0d want 35", r); end
        total++; if ({e, 9'(ic)} !== {1'b0, 9'd5}) begin bad++; $display("FAIL mr_rerun_status got err=%b ic=%0d want err=0 ic=5", e, ic); end
    endtask

    task automatic test_back_to_back;
        bit seen;
        sel = 0;
        prog_q = '{i_push(16'd3), i_push(16'd4), i_op(2'd2), i_push(16'd5), i_op(2'd3), 19'h0};
        load_rom(0);
        @(negedge clk) start = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done0) begin seen = 1; break; end
        end
        total++; if (!seen) begin bad++; $display("FAIL b2b_first_done got none want done"); end
        @(posedge clk); #1;
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL b2b_restart got busy=%b want 1", busy0); end
        @(negedge clk) start = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done0) begin seen = 1; break; end
        end
        total++; if (!seen) begin bad++; $display("FAIL b2b_second_done got none want done"); end
        total++; if ({res0, ic0} !== {16'd35, 9'd5}) begin bad++; $display("FAIL b2b_result got %0d/%0d want 35/5", res0, ic0); end
    endtask

    task automatic test_random;
        int ed, ic, st, len, ric, pick; logic [15:0] r, rr; logic e, re;
        sel = 0;
        for (int t = 0; t < 24; t++) begin
            prog_q.delete();
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) begin
                pick = $urandom_range(0, 9);
                if (pick < 4) prog_q.push_back(i_push(16'($urandom)));
                else if (pick == 4) prog_q.push_back(i_op(2'd1));
                else if (pick < 7) prog_q.push_back(i_op(2'd2));
                else if (pick < 9) prog_q.push_back(i_op(2'd3));
                else prog_q.push_back(19'h0);
            end
            load_rom(0);
            ref_run(1023, 256, rr, re, ric);
            run_prog(0, ed, r, e, ic, st);
            total++; if (r !== rr) begin bad++; $display("FAIL rnd%0d_result got %h want %h", t, r, rr); end
            total++; if (e !== re) begin bad++; $display("FAIL rnd%0d_err got %b want %b", t, e, re); end
            total++; if (ic !== ric) begin bad++; $display("FAIL rnd%0d_icount got %0d want %0d", t, ic, ric); end
            total++; if (st !== ric) begin bad++; $display("FAIL rnd%0d_steps got %0d want %0d", t, st, ric); end
            total++; if (ed !== 2 + 2 * ric) begin bad++; $display("FAIL rnd%0d_edge got %0d want %0d", t, ed, 2 + 2 * ric); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin rom0[i] = 19'h0; rom1[i] = 19'h0; end
        for (int i = 0; i < 8; i++) rom2[i] = 19'h0;
        test_reset;
        test_prog1;
        test_underflow;
        test_full;
        test_wrap;
        test_start_ignored;
        test_reset_midrun;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
